if_fetch: RTL

Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the PC, issues one-outstanding req/ack fetches to instruction memory, and presents if_pc/if_inst/if_pcplus4 to IF/ID. It honours the hazard-unit stall (pc_write) and branch/jump redirects, squashing or draining in-flight fetches. Bubbles are presented as all-zero outputs.

---
 rtl/if_fetch.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// Instruction-fetch stage feeding the IF/ID pipeline register.
// Owns the PC and keeps at most one req/ack fetch to instruction memory
// outstanding. It honours the hazard-unit stall (pc_write) and branch/jump
// redirects. A redirect that arrives while a request is held cannot cancel
// that request; the late data is drained and discarded instead.
//
// state   | meaning
// S_RUN   | no request held; request issued combinationally from fetch_pc
// S_WAIT  | request held at req_addr, returned word will be presented
// S_DRAIN | request held at req_addr, returned word will be dropped
module if_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic [31:0] if_pcplus4,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] WORD_MASK = ~32'h0000_0003;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_nxt;
    logic [31:0] req_addr;
    logic [31:0] req_addr_nxt;
    logic        req_raw;
    logic [31:0] addr_raw;
    logic        load;
    logic [31:0] load_pc;
    logic [31:0] redirect_tgt;

    // Low two bits of the redirect target are not meaningful for word fetches.
    assign redirect_tgt = redirect_pc & WORD_MASK;

    // State and address registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_RUN;
            fetch_pc <= RESET_PC;
            req_addr <= 32'h0000_0000;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            req_addr <= req_addr_nxt;
        end
    end

    // Next-state, request generation and load decision.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_addr_nxt = req_addr;
        req_raw      = 1'b0;
        addr_raw     = fetch_pc;
        load         = 1'b0;
        load_pc      = fetch_pc;

        case (state)
            S_RUN: begin
                // Only fetch when the output slot is free or being consumed.
                req_raw  = (!if_valid || pc_write) && !redirect;
                addr_raw = fetch_pc;
                if (redirect) begin
                    fetch_pc_nxt = redirect_tgt;
                end else if (req_raw) begin
                    if (imem_ack) begin
                        load         = 1'b1;
                        load_pc      = fetch_pc;
                        fetch_pc_nxt = fetch_pc + 32'd4;
                    end else begin
                        req_addr_nxt = fetch_pc;
                        state_nxt    = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                req_raw  = 1'b1;
                addr_raw = req_addr;
                if (imem_ack) begin
                    state_nxt = S_RUN;
                    if (redirect) begin
                        fetch_pc_nxt = redirect_tgt;
                    end else begin
                        load         = 1'b1;
                        load_pc      = req_addr;
                        fetch_pc_nxt = req_addr + 32'd4;
                    end
                end else if (redirect) begin
                    fetch_pc_nxt = redirect_tgt;
                    state_nxt    = S_DRAIN;
                end
            end

            S_DRAIN: begin
                req_raw  = 1'b1;
                addr_raw = req_addr;
                // Latest redirect wins while waiting for the stale word.
                if (redirect) begin
                    fetch_pc_nxt = redirect_tgt;
                end
                if (imem_ack) begin
                    state_nxt = S_RUN;
                end
            end

            default: begin
                state_nxt = S_RUN;
            end
        endcase
    end

    // Request must drop the instant reset is asserted, independent of state.
    assign imem_req  = req_raw && !rst;
    assign imem_addr = addr_raw & WORD_MASK;

    // Output register: redirect squashes, load replaces, pc_write consumes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_valid   <= 1'b0;
            if_inst    <= NOP_INST;
            if_pc      <= 32'h0000_0000;
            if_pcplus4 <= 32'h0000_0000;
        end else if (redirect) begin
            if_valid   <= 1'b0;
            if_inst    <= NOP_INST;
            if_pc      <= 32'h0000_0000;
            if_pcplus4 <= 32'h0000_0000;
        end else if (load) begin
            if_valid   <= 1'b1;
            if_inst    <= imem_rdata;
            if_pc      <= load_pc;
            if_pcplus4 <= load_pc + 32'd4;
        end else if (pc_write) begin
            if_valid   <= 1'b0;
            if_inst    <= NOP_INST;
            if_pc      <= 32'h0000_0000;
            if_pcplus4 <= 32'h0000_0000;
        end
    end

endmodule
